flit_inject_stage: RTL and testbench

//  Parametrised injection stage for the bufferless deflection router. It sits between
//  the input latches and the permutation network. Flits from CH input ports pass

---
 rtl/flit_inject_stage_if.sv | 38 +++
 rtl/flit_inject_stage.sv | 155 +++++++++++++++
 tb/tb_flit_inject_stage.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/flit_inject_stage_if.sv
// Channel/local-injection bundle for flit_inject_stage; the starve signal exists only
// when INJ_STARVE_EN is defined.
interface flit_inject_stage_if #(
   parameter int CH     = 4,
   parameter int FLIT_W = 6,
   parameter int DEPTH  = 4
);
   logic [CH-1:0]          in_valid;
   logic [CH*FLIT_W-1:0]   in_flit;
   logic                   loc_valid;
   logic [FLIT_W-1:0]      loc_flit;
   logic                   loc_ready;
   logic [CH-1:0]          out_valid;
   logic [CH*FLIT_W-1:0]   out_flit;
   logic                   inj_fire;
   logic [$clog2(CH)-1:0]  inj_port;
   logic [$clog2(DEPTH):0] fifo_count;
`ifdef INJ_STARVE_EN
   logic                   starve;
`endif

   // Master is the router side that drives channels and the local core port.
   modport master (
`ifdef INJ_STARVE_EN
      input  starve,
`endif
      output in_valid, in_flit, loc_valid, loc_flit,
      input  loc_ready, out_valid, out_flit, inj_fire, inj_port, fifo_count
   );

   modport slave (
`ifdef INJ_STARVE_EN
      output starve,
`endif
      input  in_valid, in_flit, loc_valid, loc_flit,
      output loc_ready, out_valid, out_flit, inj_fire, inj_port, fifo_count
   );
endinterface

// File: rtl/flit_inject_stage.sv
// Injection stage of the deflection router: registers through-flits and drops the local
// FIFO head into a free channel round-robin. Optional starvation flag: INJ_STARVE_EN.
module flit_inject_stage #(
   parameter int CH     = 4,
   parameter int FLIT_W = 6,
`ifdef INJ_STARVE_EN
   parameter int STARVE = 16,
`endif
   parameter int DEPTH  = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   flit_inject_stage_if.slave   bus
);
   localparam int PW = $clog2(CH);
   localparam int AW = $clog2(DEPTH);
   localparam logic [PW:0] CH_W    = (PW+1)'(CH);
   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

   logic [FLIT_W-1:0]    mem [DEPTH];
   logic [AW-1:0]        wr_ptr;
   logic [AW-1:0]        rd_ptr;
   logic [AW:0]          count;
   logic [PW-1:0]        rr_ptr;
   logic [CH-1:0]        out_valid_q;
   logic [CH*FLIT_W-1:0] out_flit_q;
   logic                 inj_fire_q;
   logic [PW-1:0]        inj_port_q;

   logic                 push;
   logic                 inject;
   logic [CH-1:0]        free;
   logic [PW-1:0]        sel;
   logic                 found;
   logic [PW:0]          scan;
   logic [PW:0]          sel_inc;
   logic [PW-1:0]        rr_next;
   logic [CH-1:0]        inj_onehot;
   logic [FLIT_W-1:0]    head;
   logic [CH-1:0]        next_valid;
   logic [CH*FLIT_W-1:0] next_flit;

   // A full FIFO refuses pushes even when the head leaves this very cycle.
   assign bus.loc_ready = (count != DEPTH_W);
   assign push          = bus.loc_valid && (count != DEPTH_W);
   assign free          = ~bus.in_valid;
   assign inject        = (count != '0) && (|free);
   assign head          = mem[rd_ptr];

   // Round-robin scan: first free channel starting at rr_ptr, wrapping mod CH.
   always_comb begin
      sel   = '0;
      found = 1'b0;
      scan  = '0;
      for (int k = 0; k < CH; k++) begin
         scan = {1'b0, rr_ptr} + (PW+1)'(k);
         if (scan >= CH_W)
            scan = scan - CH_W;
         if (!found && free[scan[PW-1:0]]) begin
            found = 1'b1;
            sel   = scan[PW-1:0];
         end
      end
   end

   always_comb begin
      sel_inc = {1'b0, sel} + (PW+1)'(1);
      rr_next = (sel_inc == CH_W) ? '0 : sel_inc[PW-1:0];
      inj_onehot = inject ? (CH'(1) << sel) : '0;
   end

   // Idle channels register zero flits so downstream never sees stale data.
   always_comb begin
      next_valid = bus.in_valid | inj_onehot;
      next_flit  = '0;
      for (int c = 0; c < CH; c++) begin
         if (inj_onehot[c])
            next_flit[c*FLIT_W +: FLIT_W] = head;
         else if (bus.in_valid[c])
            next_flit[c*FLIT_W +: FLIT_W] = bus.in_flit[c*FLIT_W +: FLIT_W];
      end
   end

   // FIFO storage is left out of reset; pointers alone define what is queued.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= bus.loc_flit;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         rr_ptr      <= '0;
         out_valid_q <= '0;
         out_flit_q  <= '0;
         inj_fire_q  <= 1'b0;
         inj_port_q  <= '0;
      end else begin
         out_valid_q <= next_valid;
         out_flit_q  <= next_flit;
         inj_fire_q  <= inject;
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (inject) begin
            rd_ptr     <= rd_ptr + 1'b1;
            rr_ptr     <= rr_next;
            inj_port_q <= sel;
         end
         case ({push, inject})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign bus.out_valid  = out_valid_q;
   assign bus.out_flit   = out_flit_q;
   assign bus.inj_fire   = inj_fire_q;
   assign bus.inj_port   = inj_port_q;
   assign bus.fifo_count = count;

`ifdef INJ_STARVE_EN
   localparam int SW = $clog2(STARVE + 1);
   localparam logic [SW-1:0] STARVE_W = SW'(STARVE);

   logic [SW-1:0] blocked_cnt;
   logic [SW-1:0] blocked_next;
   logic          starve_q;

   // Counts cycles the head waits behind a fully occupied channel set.
   always_comb begin
      blocked_next = blocked_cnt;
      if ((count == '0) || inject)
         blocked_next = '0;
      else if ((free == '0) && (blocked_cnt != STARVE_W))
         blocked_next = blocked_cnt + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         blocked_cnt <= '0;
         starve_q    <= 1'b0;
      end else begin
         blocked_cnt <= blocked_next;
         starve_q    <= (blocked_next == STARVE_W);
      end
   end

   assign bus.starve = starve_q;
`endif

endmodule

// File: tb/tb_flit_inject_stage.sv
// Randomized and directed bench for flit_inject_stage against a queue-based reference
// model; covers the starve flag too when INJ_STARVE_EN is defined.
module tb_flit_inject_stage;
   localparam int CH     = 4;
   localparam int FLIT_W = 6;
   localparam int DEPTH  = 4;
   localparam int STARVE = 16;

   logic clk = 1'b0;
   logic rst;
   int   checkCount = 0;
   int   errorCount = 0;

   always #5 clk = ~clk;

   flit_inject_stage_if #(.CH(CH), .FLIT_W(FLIT_W), .DEPTH(DEPTH)) bus ();

   flit_inject_stage #(
      .CH(CH),
      .FLIT_W(FLIT_W),
`ifdef INJ_STARVE_EN
      .STARVE(STARVE),
`endif
      .DEPTH(DEPTH)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   // Reference model state: queued local flits, next scan origin, expected outputs.
   logic [FLIT_W-1:0]    q [$];
   int                   rr = 0;
   logic [CH-1:0]        expValid = '0;
   logic [CH*FLIT_W-1:0] expFlit = '0;
   logic                 expFire = 1'b0;
   int                   expPort = 0;
   int                   blocked = 0;
   bit                   known = 1'b0;

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checkCount++;
      if (obs !== exp) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic modelStep(input logic r, input logic [CH-1:0] iv,
                            input logic [CH*FLIT_W-1:0] fl, input logic lv,
                            input logic [FLIT_W-1:0] lf);
      bit doPush;
      bit doInj;
      int sel;
      if (r) begin
         q.delete();
         rr       = 0;
         expValid = '0;
         expFlit  = '0;
         expFire  = 1'b0;
         expPort  = 0;
         blocked  = 0;
         return;
      end
      doPush = lv && (q.size() < DEPTH);
      doInj  = (q.size() > 0) && (iv != {CH{1'b1}});
      if (doInj || q.size() == 0)
         blocked = 0;
      else if (blocked < STARVE)
         blocked = blocked + 1;
      expValid = iv;
      expFlit  = '0;
      for (int c = 0; c < CH; c++)
         if (iv[c])
            expFlit[c*FLIT_W +: FLIT_W] = fl[c*FLIT_W +: FLIT_W];
      if (doInj) begin
         sel = 0;
         for (int k = 0; k < CH; k++) begin
            if (!iv[(rr + k) % CH]) begin
               sel = (rr + k) % CH;
               break;
            end
         end
         expValid[sel] = 1'b1;
         expFlit[sel*FLIT_W +: FLIT_W] = q.pop_front();
         rr      = (sel + 1) % CH;
         expPort = sel;
      end
      expFire = doInj;
      if (doPush)
         q.push_back(lf);
   endtask

   // One clock: drive on the falling edge, check loc_ready, step the model, check outputs.
   task automatic applyStimulus(input logic r, input logic [CH-1:0] iv,
                                input logic [CH*FLIT_W-1:0] fl, input logic lv,
                                input logic [FLIT_W-1:0] lf);
      @(negedge clk);
      rst           = r;
      bus.in_valid  = iv;
      bus.in_flit   = fl;
      bus.loc_valid = lv;
      bus.loc_flit  = lf;
      #1;
      if (known)
         checkOutput("loc_ready", 64'(bus.loc_ready), 64'(q.size() != DEPTH));
      modelStep(r, iv, fl, lv, lf);
      if (r)
         known = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("out_valid", 64'(bus.out_valid), 64'(expValid));
      checkOutput("out_flit", 64'(bus.out_flit), 64'(expFlit));
      checkOutput("inj_fire", 64'(bus.inj_fire), 64'(expFire));
      checkOutput("inj_port", 64'(bus.inj_port), 64'(expPort));
      checkOutput("fifo_count", 64'(bus.fifo_count), 64'(q.size()));
`ifdef INJ_STARVE_EN
      checkOutput("starve", 64'(bus.starve), 64'(blocked == STARVE));
`endif
   endtask

   function automatic logic [CH*FLIT_W-1:0] randFlits();
      logic [CH*FLIT_W-1:0] v;
      for (int c = 0; c < CH; c++)
         v[c*FLIT_W +: FLIT_W] = FLIT_W'($urandom);
      return v;
   endfunction

   initial begin
      rst           = 1'b1;
      bus.in_valid  = '0;
      bus.in_flit   = '0;
      bus.loc_valid = 1'b0;
      bus.loc_flit  = '0;

      // Reset with random inputs.
      for (int i = 0; i < 2; i++)
         applyStimulus(1'b1, CH'($urandom), randFlits(), 1'($urandom), FLIT_W'($urandom));
      checkOutput("rst_out_valid", 64'(bus.out_valid), 64'(0));
      checkOutput("rst_fifo_count", 64'(bus.fifo_count), 64'(0));
      checkOutput("rst_loc_ready", 64'(bus.loc_ready), 64'(1));

      // Pass-through with all channels busy while a local flit is queued.
      applyStimulus(1'b0, 4'b1111, {6'h11, 6'h22, 6'h33, 6'h05}, 1'b1, 6'h3F);
      checkOutput("pt_out_flit", 64'(bus.out_flit), 64'({6'h11, 6'h22, 6'h33, 6'h05}));
      checkOutput("pt_inj_fire", 64'(bus.inj_fire), 64'(0));
      checkOutput("pt_fifo_count", 64'(bus.fifo_count), 64'(1));

      // Injection into channel 1 with rr_ptr at 0.
      applyStimulus(1'b1, '0, '0, 1'b0, '0);
      applyStimulus(1'b0, 4'b1111, randFlits(), 1'b1, 6'h20);
      applyStimulus(1'b0, 4'b0101, {6'h01, 6'h02, 6'h03, 6'h04}, 1'b0, '0);
      checkOutput("inj_out_valid", 64'(bus.out_valid), 64'(4'b0111));
      checkOutput("inj_flit1", 64'(bus.out_flit[FLIT_W +: FLIT_W]), 64'(6'h20));
      checkOutput("inj_port1", 64'(bus.inj_port), 64'(1));
      applyStimulus(1'b0, 4'b1111, randFlits(), 1'b1, 6'h2A);
      applyStimulus(1'b0, 4'b0000, '0, 1'b0, '0);
      checkOutput("inj_rr_next", 64'(bus.inj_port), 64'(2));

      // Round-robin over four queued flits.
      applyStimulus(1'b1, '0, '0, 1'b0, '0);
      for (int i = 0; i < 4; i++)
         applyStimulus(1'b0, 4'b1111, randFlits(), 1'b1, FLIT_W'(8 + i));
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 4'b0000, '0, 1'b0, '0);
         checkOutput("rr_port", 64'(bus.inj_port), 64'(i));
      end
      checkOutput("rr_empty", 64'(bus.fifo_count), 64'(0));

      // Full FIFO refuses a fifth push; freeing channel 2 drains one.
      applyStimulus(1'b1, '0, '0, 1'b0, '0);
      for (int i = 0; i < 4; i++)
         applyStimulus(1'b0, 4'b1111, randFlits(), 1'b1, FLIT_W'(16 + i));
      checkOutput("full_count", 64'(bus.fifo_count), 64'(4));
      checkOutput("full_ready", 64'(bus.loc_ready), 64'(0));
      applyStimulus(1'b0, 4'b1111, randFlits(), 1'b1, 6'h3E);
      checkOutput("full_ignored", 64'(bus.fifo_count), 64'(4));
      applyStimulus(1'b0, 4'b1011, randFlits(), 1'b0, '0);
      checkOutput("full_port2", 64'(bus.inj_port), 64'(2));
      checkOutput("full_drain", 64'(bus.fifo_count), 64'(3));
      checkOutput("full_flit2", 64'(bus.out_flit[2*FLIT_W +: FLIT_W]), 64'(16));

`ifdef INJ_STARVE_EN
      // Head blocked until the starve flag rises, then released.
      applyStimulus(1'b1, '0, '0, 1'b0, '0);
      applyStimulus(1'b0, 4'b1111, randFlits(), 1'b1, 6'h15);
      for (int i = 0; i < STARVE; i++)
         applyStimulus(1'b0, 4'b1111, randFlits(), 1'b0, '0);
      checkOutput("starve_set", 64'(bus.starve), 64'(1));
      applyStimulus(1'b0, 4'b1101, randFlits(), 1'b0, '0);
      checkOutput("starve_clear", 64'(bus.starve), 64'(0));
      checkOutput("starve_inj", 64'(bus.inj_fire), 64'(1));
`endif

      // Random traffic with occasional mid-run resets.
      for (int i = 0; i < 800; i++) begin
         logic [CH-1:0] iv;
         iv = ($urandom_range(0, 3) == 0) ? {CH{1'b1}} : CH'($urandom);
         applyStimulus(($urandom_range(0, 99) == 0), iv, randFlits(),
                       ($urandom_range(0, 2) != 0), FLIT_W'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end
endmodule
